key_switch_reader: RTL and testbench

Input-side bus peripheral. Captures the board's raw push-buttons and slide switches, then synchronizes and debounces them. It detects key press events and latches them into sticky status bits. All state is presented to the CPU through a simple single-cycle register read/write port with an interrupt output. It sits between the board pins (KEY, SW) and the system bus decode, as the complement to the LED/seven-segment output path.

---
 rtl/key_switch_reader_pkg.sv | 13 +
 rtl/debounce_bit.sv | 52 +++++
 rtl/key_switch_reader.sv | 122 ++++++++++++
 tb/tb_key_switch_reader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_switch_reader_pkg.sv
// Shared constants for the key/switch reader: register addresses and bus width.
// The optional RELEASE register is enabled by defining KEY_SW_RELEASE_EVENT_EN.
package key_switch_reader_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ADDR_SWITCHES = 3'd0;
  localparam logic [2:0] ADDR_KEYS     = 3'd1;
  localparam logic [2:0] ADDR_PRESS    = 3'd2;
  localparam logic [2:0] ADDR_MASK     = 3'd3;
  localparam logic [2:0] ADDR_RELEASE  = 3'd4;

endpackage

// File: rtl/debounce_bit.sv
// One input bit: two-flop synchronizer, stability counter and accepted level q.
// 'change' pulses in the cycle before q flips, so callers can log the edge on the same clock edge.
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic q,
  output logic change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             lvl_q, lvl_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differs;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    differs = (sync2_q != lvl_q);
    lvl_d   = lvl_q;
    cnt_d   = '0;
    // Any cycle where the synchronized value agrees with q restarts the count.
    if (differs) begin
      if (cnt_q == CNT_LAST) lvl_d = sync2_q;
      else                   cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      lvl_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q      = lvl_q;
  assign change = differs && (cnt_q == CNT_LAST);

endmodule

// File: rtl/key_switch_reader.sv
// Debounced push-button / slide-switch reader with sticky press bits, mask and level irq.
// Define KEY_SW_RELEASE_EVENT_EN to add the sticky RELEASE register at address 4.
module key_switch_reader
  import key_switch_reader_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int N_SW            = 10,
  parameter int DEBOUNCE_CYCLES = 1000000,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic              clock_50_MHz,
  input  logic              reset_n,
  input  logic [N_KEYS-1:0] key_n,
  input  logic [N_SW-1:0]   sw,
  input  logic              sel,
  input  logic              wr,
  input  logic [2:0]        addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              irq
);

  localparam int N_ALL = N_KEYS + N_SW;

  logic [N_ALL-1:0]  raw, lvl, chg;
  logic [N_KEYS-1:0] key_lvl, key_rise, wclr;
  logic [N_SW-1:0]   sw_lvl;
  logic              wr_en, rd_en;
  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] mask_q, mask_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_mux;
  logic              irq_q, irq_d;
  logic [N_KEYS-1:0] event_bits;
  logic              unused_bits;

  // Keys are inverted ahead of the synchronizer so that 1 means pressed everywhere inside.
  assign raw = {sw, ~key_n};

  for (genvar i = 0; i < N_ALL; i++) begin : g_db
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk   (clock_50_MHz),
      .rst_n (reset_n),
      .din   (raw[i]),
      .q     (lvl[i]),
      .change(chg[i])
    );
  end

  assign key_lvl     = lvl[N_KEYS-1:0];
  assign sw_lvl      = lvl[N_ALL-1:N_KEYS];
  assign key_rise    = chg[N_KEYS-1:0] & ~key_lvl;
  assign wr_en       = sel & wr;
  assign rd_en       = sel & ~wr;
  assign wclr        = wdata[N_KEYS-1:0];
  assign unused_bits = ^{chg[N_ALL-1:N_KEYS], wdata[DATA_W-1:N_KEYS]};

`ifdef KEY_SW_RELEASE_EVENT_EN
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] key_fall;

  assign key_fall   = chg[N_KEYS-1:0] & key_lvl;
  assign event_bits = press_q | release_q;

  always_comb begin
    release_d = release_q;
    if (wr_en && addr == ADDR_RELEASE) release_d = release_q & ~wclr;
    release_d = release_d | key_fall;
  end

  always_ff @(posedge clock_50_MHz or negedge reset_n) begin
    if (!reset_n) release_q <= '0;
    else          release_q <= release_d;
  end
`else
  assign event_bits = press_q;
`endif

  always_comb begin
    // Clear first, then OR in new events so a same-cycle press survives the W1C.
    press_d = press_q;
    if (wr_en && addr == ADDR_PRESS) press_d = press_q & ~wclr;
    press_d = press_d | key_rise;

    mask_d = mask_q;
    if (wr_en && addr == ADDR_MASK) mask_d = wclr;

    case (addr)
      ADDR_SWITCHES: rd_mux = DATA_W'(sw_lvl);
      ADDR_KEYS:     rd_mux = DATA_W'(key_lvl);
      ADDR_PRESS:    rd_mux = DATA_W'(press_q);
      ADDR_MASK:     rd_mux = DATA_W'(mask_q);
`ifdef KEY_SW_RELEASE_EVENT_EN
      ADDR_RELEASE:  rd_mux = DATA_W'(release_q);
`endif
      default:       rd_mux = '0;
    endcase

    rdata_d = rd_en ? rd_mux : rdata_q;
    irq_d   = |(event_bits & mask_q);
  end

  always_ff @(posedge clock_50_MHz or negedge reset_n) begin
    if (!reset_n) begin
      press_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      press_q <= press_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = irq_q;

endmodule

// File: tb/tb_key_switch_reader.sv
// Directed bench for key_switch_reader with a window-based reference model checked every cycle.
// Honours KEY_SW_RELEASE_EVENT_EN for the RELEASE register expectations.
module tb_key_switch_reader;

  localparam int N_KEYS = 4;
  localparam int N_SW   = 10;
  localparam int DEB    = 4;
  localparam int N_ALL  = N_KEYS + N_SW;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [N_KEYS-1:0] key_n;
  logic [N_SW-1:0]   sw;
  logic              sel, wr;
  logic [2:0]        addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              irq;

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  key_switch_reader #(
    .N_KEYS         (N_KEYS),
    .N_SW           (N_SW),
    .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clock_50_MHz(clk),
    .reset_n     (reset_n),
    .key_n       (key_n),
    .sw          (sw),
    .sel         (sel),
    .wr          (wr),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .irq         (irq)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // A level is accepted once the pin, seen two cycles late, has held it for DEB consecutive samples.
  logic [N_ALL-1:0]  hist [0:DEB+1];
  logic [N_ALL-1:0]  m_q = '0;
  logic [N_ALL-1:0]  m_nq;
  logic [N_KEYS-1:0] m_press = '0, m_mask = '0, m_rel = '0;
  logic [N_KEYS-1:0] m_rise, m_fall;
  logic [31:0]       m_rdata = '0;
  logic              m_irq = 1'b0, m_irq_n;
  bit                all1, all0;

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {22'd0, m_q[N_ALL-1:N_KEYS]};
      3'd1: return {28'd0, m_q[N_KEYS-1:0]};
      3'd2: return {28'd0, m_press};
      3'd3: return {28'd0, m_mask};
`ifdef KEY_SW_RELEASE_EVENT_EN
      3'd4: return {28'd0, m_rel};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i <= DEB + 1; i++) hist[i] = '0;
    m_q = '0; m_press = '0; m_mask = '0; m_rel = '0; m_rdata = '0; m_irq = 1'b0;
  endtask

  task automatic model_step();
    for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = {sw, ~key_n};
    m_nq = m_q;
    for (int b = 0; b < N_ALL; b++) begin
      all1 = 1'b1;
      all0 = 1'b1;
      for (int k = 2; k <= DEB + 1; k++) begin
        if (hist[k][b]) all0 = 1'b0;
        else            all1 = 1'b0;
      end
      if (all1)      m_nq[b] = 1'b1;
      else if (all0) m_nq[b] = 1'b0;
    end
    m_rise = m_nq[N_KEYS-1:0] & ~m_q[N_KEYS-1:0];
    m_fall = ~m_nq[N_KEYS-1:0] & m_q[N_KEYS-1:0];
`ifdef KEY_SW_RELEASE_EVENT_EN
    m_irq_n = |((m_press | m_rel) & m_mask);
`else
    m_irq_n = |(m_press & m_mask);
`endif
    if (sel && !wr) m_rdata = model_read(addr);
    if (sel && wr && addr == 3'd2) m_press = m_press & ~wdata[N_KEYS-1:0];
    m_press = m_press | m_rise;
`ifdef KEY_SW_RELEASE_EVENT_EN
    if (sel && wr && addr == 3'd4) m_rel = m_rel & ~wdata[N_KEYS-1:0];
    m_rel = m_rel | m_fall;
`endif
    if (sel && wr && addr == 3'd3) m_mask = wdata[N_KEYS-1:0];
    m_irq = m_irq_n;
    m_q   = m_nq;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) model_reset();
      else          model_step();
    end
  end

  // Per-cycle comparison, well clear of both clock edges.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (reset_n && cmp_en) begin
        check("rdata_model", rdata, m_rdata);
        check("irq_model", {31'd0, irq}, {31'd0, m_irq});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    sel = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    sel = 1'b0;
    d = rdata;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] v);
    sel = 1'b1; wr = 1'b1; addr = a; wdata = v;
    @(negedge clk);
    sel = 1'b0; wr = 1'b0; wdata = '0;
  endtask

  // ---------------- directed sequence ----------------
  logic [31:0] rd;
  logic [31:0] exp_rel;

  initial begin
    reset_n = 1'b0; key_n = '1; sw = '0;
    sel = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    tick(3);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Idle after reset: every address reads zero and irq is low.
    check("reset_irq", {31'd0, irq}, 32'd0);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check($sformatf("reset_read_%0d", a), rd, 32'd0);
    end

    // Switch level appears after 2 + DEB cycles; a 3-cycle glitch is rejected.
    sw = 10'h2A5;
    tick(4);
    bus_read(3'd0, rd);
    check("sw_too_early", rd, 32'd0);
    tick(3);
    bus_read(3'd0, rd);
    check("sw_settled", rd, 32'h2A5);
    sw = 10'h2A4;
    tick(3);
    sw = 10'h2A5;
    tick(10);
    bus_read(3'd0, rd);
    check("sw_glitch", rd, 32'h2A5);

    // Key 2 press with mask: PRESS sets at edge 6, irq one edge later.
    bus_write(3'd3, 32'h4);
    key_n = 4'b1011;
    tick(6);
    check("irq_lags_press", {31'd0, irq}, 32'd0);
    tick(1);
    check("irq_on_press", {31'd0, irq}, 32'd1);
    bus_read(3'd1, rd);
    check("keys_held", rd, 32'h4);
    key_n = 4'hF;
    bus_read(3'd2, rd);
    check("press_set", rd, 32'h4);
    bus_write(3'd2, 32'h4);
    bus_read(3'd2, rd);
    check("press_cleared", rd, 32'h0);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    tick(10);
    bus_write(3'd4, 32'hF);
    tick(2);
    check("irq_idle", {31'd0, irq}, 32'd0);

    // Press event on key 1 coincides with a W1C of that bit: the set wins.
    key_n = 4'b1101;
    tick(5);
    bus_write(3'd2, 32'h2);
    bus_read(3'd2, rd);
    check("set_wins", rd, 32'h2);
    key_n = 4'hF;
    tick(10);
    bus_write(3'd2, 32'hF);
    bus_write(3'd4, 32'hF);

    // Reset mid-count on key 0, then PRESS[0] sets exactly 6 edges after release.
    key_n = 4'b1110;
    tick(4);
    reset_n = 1'b0;
    tick(1);
    check("reset_rdata", rdata, 32'd0);
    check("reset_irq2", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    tick(5);
    bus_read(3'd2, rd);
    check("press_not_yet", rd, 32'h0);
    bus_read(3'd2, rd);
    check("press_exact", rd, 32'h1);
    bus_read(3'd3, rd);
    check("mask_after_reset", rd, 32'h0);
    bus_read(3'd0, rd);
    check("sw_after_reset", rd, 32'h2A5);

    // Press and release key 3 while key 0 stays held.
    key_n = 4'b0110;
    tick(8);
    key_n = 4'b1110;
    tick(8);
`ifdef KEY_SW_RELEASE_EVENT_EN
    exp_rel = 32'h8;
`else
    exp_rel = 32'h0;
`endif
    bus_read(3'd4, rd);
    check("release_reg", rd, exp_rel);
    bus_read(3'd2, rd);
    check("press_k0_k3", rd, 32'h9);
    bus_read(3'd1, rd);
    check("keys_k0", rd, 32'h1);
    bus_write(3'd5, 32'hFFFF_FFFF);
    bus_read(3'd5, rd);
    check("addr5_zero", rd, 32'h0);
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
